// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: state encoding,
// bus widths and the address legality check.
package dmem_pkg;

   localparam int DATA_W   = 32;
   localparam int BE_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // A request is rejected when it is not word aligned or falls past the array.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array built from one byte-wide RAM per lane, so each byte enable maps
// onto its own write port; read data is registered on the access edge.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int  DEPTH_WORDS = 256,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                i_en,
   input  logic                i_we,
   input  logic [AW-1:0]       i_idx,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [BE_WIDTH-1:0] i_be,
   output logic [DATA_W-1:0]   o_rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
         logic [7:0] r_mem [DEPTH_WORDS];
         logic [7:0] r_rd;

         // Stores return zero data, so the read register is cleared on a write.
         always_ff @(posedge clk) begin
            if (i_en) begin
               if (i_we) begin
                  if (i_be[gi]) begin
                     r_mem[i_idx] <= i_wdata[8*gi +: 8];
                  end
                  r_rd <= 8'h00;
               end else begin
                  r_rd <= r_mem[i_idx];
               end
            end
         end

         assign o_rdata[8*gi +: 8] = r_rd;
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's load/store channel: accepts one request, waits a
// fixed number of cycles, commits it to the array, then holds the response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      r_state, w_state_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_err;

   logic        w_accept, w_commit, w_resp_done;
   logic        w_c_we, w_c_err, w_mem_en;
   logic [31:0] w_c_addr, w_c_wdata;
   logic [3:0]  w_c_be;
   logic [31:0] w_arr_rdata;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      w_resp_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_accept   = 1'b1;
               w_cnt_next = WAIT_INIT;
               if (WAIT_CYCLES == 0) begin
                  w_commit     = 1'b1;
                  w_state_next = RESP;
               end else begin
                  w_state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_commit     = 1'b1;
               w_cnt_next   = 4'd0;
               w_state_next = RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               w_resp_done  = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // With zero wait states the commit shares the accept edge, so it must see
   // the live request rather than the latched copy.
   always_comb begin
      w_c_we    = r_we;
      w_c_addr  = r_addr;
      w_c_wdata = r_wdata;
      w_c_be    = r_be;
      if (r_state == IDLE) begin
         w_c_we    = req_we;
         w_c_addr  = req_addr;
         w_c_wdata = req_wdata;
         w_c_be    = req_be;
      end
   end

   assign w_c_err  = addr_err(w_c_addr, DEPTH_WORDS);
   assign w_mem_en = w_commit & ~w_c_err & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end
         if (w_commit) begin
            r_err <= w_c_err;
         end else if (w_resp_done) begin
            r_err <= 1'b0;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .i_en    (w_mem_en),
      .i_we    (w_c_we),
      .i_idx   (w_c_addr[AW+1:2]),
      .i_wdata (w_c_wdata),
      .i_be    (w_c_be),
      .o_rdata (w_arr_rdata)
   );

   assign req_ready  = (r_state == IDLE) & ~rst;
   assign resp_valid = (r_state == RESP);
   assign resp_err   = r_err;
   // Stores and rejected requests report zero data.
   assign resp_rdata = (r_state == RESP && !r_err && !r_we) ? w_arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 4 and 0 wait states) exercised
// by scenario tasks; expected responses flow through a scoreboard queue.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  req_valid, req_ready, req_we;
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic [2:0]  resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata [3];

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] sb_rd  [$];
   logic        sb_err [$];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS (256),
         .WAIT_CYCLES ((gi == 0) ? 2 : ((gi == 1) ? 4 : 0))
      ) u_dut (
         .clk        (clk),
         .rst        (rst[gi]),
         .req_valid  (req_valid[gi]),
         .req_ready  (req_ready[gi]),
         .req_we     (req_we[gi]),
         .req_addr   (req_addr[gi]),
         .req_wdata  (req_wdata[gi]),
         .req_be     (req_be[gi]),
         .resp_valid (resp_valid[gi]),
         .resp_ready (resp_ready[gi]),
         .resp_rdata (resp_rdata[gi]),
         .resp_err   (resp_err[gi])
      );
   end

   function automatic int wt(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 4 : 0);
   endfunction

   // Present a request and return just after its accept edge; the request
   // lines are then scrambled so a late sample would corrupt the result.
   task automatic send(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
      int n = 0;
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      while (req_ready[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (req_ready[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", d, req_ready[d]);
      end
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_we[d]    = ~we;
      req_addr[d]  = 32'hFFFF_FFFC;
      req_wdata[d] = ~wdata;
      req_be[d]    = ~be;
   endtask

   // Wait for resp_valid, check latency, then pop and compare the scoreboard.
   task automatic await_resp(input int d, input string name);
      int          lat = 0;
      logic [31:0] er;
      logic        ee;
      @(negedge clk);
      while (resp_valid[d] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      er = sb_rd.pop_front();
      ee = sb_err.pop_front();
      n_tests++;
      if (resp_valid[d] !== 1'b1 || lat != wt(d)) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges (valid=%b) required %0d", name, lat, resp_valid[d], wt(d));
      end
      n_tests++;
      if (resp_rdata[d] !== er) begin
         n_fail++;
         $display("FAIL %s rdata: got %h required %h", name, resp_rdata[d], er);
      end
      n_tests++;
      if (resp_err[d] !== ee) begin
         n_fail++;
         $display("FAIL %s err: got %b required %b", name, resp_err[d], ee);
      end
      $display("[TB] dut%0d %s: lat=%0d rdata=%h err=%b", d, name, lat, resp_rdata[d], resp_err[d]);
   endtask

   task automatic txn(input int d, input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err);
      sb_rd.push_back(exp_rd);
      sb_err.push_back(exp_err);
      send(d, we, addr, wdata, be);
      await_resp(d, name);
      @(negedge clk);
      n_tests++;
      if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s turnaround: valid=%b ready=%b required 0/1", name, resp_valid[d], req_ready[d]);
      end
   endtask

   task automatic test_reset;
      rst = 3'b111;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: ready=%b valid=%b err=%b rdata=%h required all 0",
                     d, req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]);
         end
      end
      rst = 3'b000;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if (req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release dut%0d: req_ready=%b required 1", d, req_ready[d]);
         end
      end
      $display("[TB] reset checked");
   endtask

   task automatic test_word;
      txn(0, "word_store", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
      txn(0, "word_load", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
   endtask

   task automatic test_byte_merge;
      txn(0, "merge_full", 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0);
      txn(0, "merge_part", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
      txn(0, "merge_load", 1'b0, 32'h20, 32'h0, 4'b1111, 32'h11BB33DD, 1'b0);
      txn(0, "be_zero", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
      txn(0, "be_zero_load", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);
   endtask

   task automatic test_errors;
      txn(0, "seed_0", 1'b1, 32'h0, 32'h5A5A5A5A, 4'b1111, 32'h0, 1'b0);
      txn(0, "misaligned", 1'b0, 32'h22, 32'h0, 4'b0000, 32'h0, 1'b1);
      txn(0, "out_of_range", 1'b1, 32'h400, 32'h12345678, 4'b1111, 32'h0, 1'b1);
      txn(0, "after_oor", 1'b0, 32'h0, 32'h0, 4'b0000, 32'h5A5A5A5A, 1'b0);
      txn(0, "last_word", 1'b1, 32'h3FC, 32'h0BADCAFE, 4'b1111, 32'h0, 1'b0);
      txn(0, "last_load", 1'b0, 32'h3FC, 32'h0, 4'b0000, 32'h0BADCAFE, 1'b0);
   endtask

   task automatic test_backpressure;
      logic [31:0] rd0;
      logic        er0;
      resp_ready[0] = 1'b0;
      sb_rd.push_back(32'hDEADBEEF);
      sb_err.push_back(1'b0);
      send(0, 1'b0, 32'h10, 32'h0, 4'b0000);
      await_resp(0, "bp_load");
      rd0 = resp_rdata[0];
      er0 = resp_err[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 ||
             resp_rdata[0] !== rd0 || resp_err[0] !== er0) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d: valid=%b ready=%b rdata=%h err=%b required 1/0/%h/%b",
                     i, resp_valid[0], req_ready[0], resp_rdata[0], resp_err[0], rd0, er0);
         end
      end
      resp_ready[0] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b ready=%b required 0/1", resp_valid[0], req_ready[0]);
      end
      $display("[TB] dut0 backpressure released");
   endtask

   task automatic test_reset_mid_wait;
      bit seen = 1'b0;
      txn(1, "rw_clear", 1'b1, 32'h30, 32'h0, 4'b1111, 32'h0, 1'b0);
      send(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111);
      repeat (2) @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({req_ready[1], resp_valid[1], resp_err[1], resp_rdata[1]} !== 35'd0) begin
         n_fail++;
         $display("FAIL rw_reset_outputs: ready=%b valid=%b err=%b rdata=%h required all 0",
                  req_ready[1], resp_valid[1], resp_err[1], resp_rdata[1]);
      end
      rst[1] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (req_ready[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL rw_ready: req_ready=%b required 1", req_ready[1]);
      end
      for (int i = 0; i < 6; i++) begin
         if (resp_valid[1] === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL rw_no_resp: resp_valid=1 seen required 0");
      end
      txn(1, "rw_load", 1'b0, 32'h30, 32'h0, 4'b0000, 32'h0, 1'b0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] vals [4];
      int k = 0, got = 0, last_issue = -10, last_resp = -10, cyc = 0;
      for (int i = 0; i < 4; i++) begin
         vals[i] = 32'h0101_0101 * (i + 1) + 32'h100;
         txn(2, "b2b_store", 1'b1, 32'h40 + 4 * i, vals[i], 4'b1111, 32'h0, 1'b0);
      end
      while (got < 4 && cyc < 40) begin
         if (resp_valid[2] === 1'b1) begin
            logic [31:0] er;
            logic        ee;
            er = sb_rd.pop_front();
            ee = sb_err.pop_front();
            n_tests++;
            if (resp_rdata[2] !== er || resp_err[2] !== ee || cyc != last_issue + 1 ||
                (got > 0 && cyc != last_resp + 2)) begin
               n_fail++;
               $display("FAIL b2b_load %0d: rdata=%h err=%b cyc=%0d required %h/%b issue+1=%0d prev+2=%0d",
                        got, resp_rdata[2], resp_err[2], cyc, er, ee, last_issue + 1, last_resp + 2);
            end
            $display("[TB] dut2 b2b_load %0d: cyc=%0d rdata=%h", got, cyc, resp_rdata[2]);
            last_resp = cyc;
            got++;
         end
         if (req_ready[2] === 1'b1 && k < 4) begin
            req_valid[2] = 1'b1;
            req_we[2]    = 1'b0;
            req_addr[2]  = 32'h40 + 4 * k;
            req_be[2]    = 4'b0000;
            sb_rd.push_back(vals[k]);
            sb_err.push_back(1'b0);
            last_issue = cyc;
            k++;
         end else if (req_ready[2] === 1'b1) begin
            req_valid[2] = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid[2] = 1'b0;
      n_tests++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d responses required 4", got);
      end
   endtask

   initial begin
      rst        = 3'b111;
      req_valid  = 3'b000;
      req_we     = 3'b000;
      resp_ready = 3'b111;
      for (int d = 0; d < 3; d++) begin
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
         req_be[d]    = 4'h0;
      end
      @(negedge clk);
      test_reset();
      test_word();
      test_byte_merge();
      test_errors();
      test_backpressure();
      test_reset_mid_wait();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32 core: the target end of the core's load/store request channel. It accepts one word-aligned load or store at a time over a valid/ready handshake. After a programmable number of wait states it commits the access to an internal word array. It then returns a response (read data or write acknowledge, plus an error flag) over a second valid/ready handshake, which lets the core's memory stage be exercised against non-zero memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 256 — number of 32-bit words in the array (power of two, ≥ 4).
- WAIT_CYCLES, 2 — wait states between request accept and access commit (0–15).

Ports:
- clk  input  1  — single clock; all logic on the rising edge.
- rst  input  1  — synchronous, active-high reset.
- req_valid  input  1  — core presents a request.
- req_ready  output  1  — responder can accept a request.
- req_we  input  1  — 1 = store, 0 = load.
- req_addr  input  32  — byte address.
- req_wdata  input  32  — store data, byte lanes aligned to the word.
- req_be  input  4  — store byte enables; ignored for loads.
- resp_valid  output  1  — response available.
- resp_ready  input  1  — core accepts the response.
- resp_rdata  output  32  — load data; 0 for stores and errors.
- resp_err  output  1  — request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid & req_ready, latch we/addr/wdata/be.
  - Load WAIT_CYCLES into the down-counter.
  - Go to WAIT, or directly to the commit step if WAIT_CYCLES = 0.
- **WAIT**
  - req_ready = 0; the counter decrements each cycle.
  - When the counter reaches 1, the next edge commits and enters RESP.
- **Commit** happens on the edge entering RESP.
  - Error check: error = (addr[1:0] ≠ 0) or (addr[31:2] ≥ DEPTH_WORDS).
  - On error: no array write, resp_rdata = 0, resp_err = 1.
  - Store: for each byte lane i with be[i] = 1, array[addr[31:2]] byte i ← wdata byte i. Other lanes are unchanged. resp_rdata = 0.
  - Load: resp_rdata = array[addr[31:2]].
- **RESP**
  - resp_valid = 1 and req_ready = 0.
  - resp_rdata and resp_err hold stable until resp_valid & resp_ready.
  - On that handshake, go to IDLE.
- At most one request is outstanding; there is no pipelining across requests.
- A store with be = 0000 is legal: no bytes change, and it is acknowledged normally.
- Array contents are not cleared by rst; contents are undefined until written.

## Timing
- Reset values: req_ready = 0 during rst, then 1 in the first cycle after rst deasserts. resp_valid = 0, resp_rdata = 0, resp_err = 0, state = IDLE, counter = 0.
- Accept at edge t → resp_valid first high in cycle t+1+WAIT_CYCLES.
- Back-to-back throughput: minimum 2+WAIT_CYCLES cycles per request, with resp_ready held high.
- resp_ready low stalls indefinitely in RESP with outputs held.
- Response-to-request turnaround: the response handshake at edge r puts the block in IDLE, so req_ready = 1 in cycle r+1. A request cannot be accepted in the same cycle as a response handshake.
- rst asserted in any state forces IDLE on that edge:
  - A request still in WAIT is discarded with no array write.
  - A store already committed (in RESP) stays written.
- req_* inputs are sampled only on the accept edge; changes while busy are ignored.

## Structure
- Shared package (dmem_pkg): state enum (IDLE/WAIT/RESP), BE_WIDTH = 4, DATA_W = 32, error-check function.
- One sub-module, dmem_array: DEPTH_WORDS × 32 synchronous array with per-byte write enable.
  - Read data is registered on the commit edge.
  - The FSM, counter and handshake logic live in dmem_responder.

## Test plan
- **Word store/load:** WAIT_CYCLES = 2, store 0xDEADBEEF to 0x10 with be = 1111, then load 0x10 → resp_rdata = 0xDEADBEEF, resp_err = 0. resp_valid rises 3 cycles after each accept.
- **Byte-lane merge:** store 0x11223344 to 0x20 with be = 1111, then store 0xAABBCCDD with be = 0101, then load 0x20 → 0x11BB33DD.
- **Errors:**
  - Load 0x22 (misaligned) → resp_err = 1, rdata = 0.
  - Store to byte address 4·DEPTH_WORDS (0x400 for 256 words) → resp_err = 1; a following load of 0x0 is unchanged.
- **Backpressure:** hold resp_ready = 0 for 5 cycles in RESP → resp_valid, resp_rdata and resp_err stable, req_ready = 0. Release → IDLE next cycle, req_ready = 1.
- **Reset mid-WAIT:** WAIT_CYCLES = 4, store 0xCAFEF00D to 0x30 after 0x30 holds 0x0, assert rst for 1 cycle during WAIT. All outputs return to reset values; a later load of 0x30 → 0x0.
- **Zero wait:** WAIT_CYCLES = 0, back-to-back loads with resp_ready tied high → one response every 2 cycles, each resp_valid one cycle after its accept.
